// File: rtl/sigma_delta_decimator.sv
// Second-order CIC (sinc2) decimator for a 1-bit sigma-delta stream.
// Integrators advance on en_i strobes; comb and output stages follow on the next two clocks.
module sigma_delta_decimator #(
  parameter int BW    = 8,
  parameter int RLOG2 = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          bit_i,
  output logic [BW-1:0] data_o,
  output logic          valid_o,
  output logic          sat_o
);

  localparam int W     = 2*RLOG2 + 2;
  localparam int S     = 2*RLOG2 + 1 - BW;
  localparam int MAX_I = (1 << (BW-1)) - 1;
  localparam int MIN_I = -(1 << (BW-1));

  logic [W-1:0]        i1_q, i1_d, i2_q, i2_d;
  logic [W-1:0]        snap_q, snap_dly_q, c1_dly_q, c2_q;
  logic [W-1:0]        c1_d, c2_d;
  logic [RLOG2-1:0]    phase_q;
  logic                e1_q, e2_q, primed_q;
  logic [BW-1:0]       data_q, data_d;
  logic                valid_q, sat_q, sat_d;
  logic                dec_strobe;
  logic signed [W-1:0] y;
  int                  y_int;

  always_comb begin
    // NOTE: every signal gets an unconditional assignment before any branch, so no latch is inferred.
    i1_d       = i1_q + (bit_i ? W'(1) : {W{1'b1}});
    i2_d       = i2_q + i1_d;
    dec_strobe = en_i && (phase_q == '1);
    // Differences wrap modulo 2^W; the true comb output always fits in W bits.
    c1_d       = snap_q - snap_dly_q;
    c2_d       = c1_d - c1_dly_q;
    y          = $signed(c2_q) >>> S;
    y_int      = int'(y);
    data_d     = y[BW-1:0];
    sat_d      = 1'b0;
    if (y_int > MAX_I) begin
      data_d = BW'(MAX_I);
      sat_d  = 1'b1;
    end else if (y_int < MIN_I) begin
      data_d = BW'(MIN_I);
      sat_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      i1_q       <= '0;
      i2_q       <= '0;
      phase_q    <= '0;
      snap_q     <= '0;
      snap_dly_q <= '0;
      c1_dly_q   <= '0;
      c2_q       <= '0;
      e1_q       <= 1'b0;
      e2_q       <= 1'b0;
      primed_q   <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let E0 overwrite snap_q on the same edge E1 reads the old value.
      e1_q    <= dec_strobe;
      e2_q    <= e1_q;
      valid_q <= 1'b0;
      if (en_i) begin
        i1_q    <= i1_d;
        i2_q    <= i2_d;
        phase_q <= phase_q + RLOG2'(1);
      end
      if (dec_strobe) snap_q <= i2_d;
      if (e1_q) begin
        snap_dly_q <= snap_q;
        c1_dly_q   <= c1_d;
        c2_q       <= c2_d;
      end
      // The first result after reset has no valid comb history and is dropped.
      if (e2_q) begin
        if (primed_q) begin
          data_q  <= data_d;
          sat_q   <= sat_d;
          valid_q <= 1'b1;
        end
        primed_q <= 1'b1;
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign sat_o   = sat_q;

endmodule

// File: tb/tb_sigma_delta_decimator.sv
// Directed bench for sigma_delta_decimator (BW=8, RLOG2=4): constant, alternating,
// 75% density with and without en_i gaps, and mid-pipeline reset.
module tb_sigma_delta_decimator;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       en_i  = 1'b0;
  logic       bit_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o;
  logic       sat_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int strobes  = 0;
  int v_due    = -1;

  sigma_delta_decimator #(.BW(8), .RLOG2(4)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (en_i),
    .bit_i   (bit_i),
    .data_o  (data_o),
    .valid_o (valid_o),
    .sat_o   (sat_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    en_i  = 1'b0;
    bit_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i   = 1'b1;
    cyc     = 0;
    strobes = 0;
    v_due   = -1;
  endtask

  // Drives n_strobes bits of a 4-bit repeating pattern (pat[0] first), then flush idle cycles.
  // A result is due 2 cycles after every 16th strobe, from the second frame on.
  task automatic run(input string tag, input logic [3:0] pat, input int n_strobes, input bit gaps,
                     input logic [7:0] exp_data, input logic exp_sat, input int exp_valids,
                     input int flush);
    int   n_valid = 0;
    int   budget  = 0;
    int   flushed = 0;
    logic exp_v;
    while ((strobes < n_strobes || flushed < flush) && budget < 2000) begin
      if (strobes < n_strobes) begin
        en_i  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        bit_i = en_i ? pat[strobes % 4] : 1'($urandom_range(0, 1));
      end else begin
        en_i  = 1'b0;
        bit_i = 1'b0;
        flushed++;
      end
      @(posedge clk_i);
      #1;
      cyc++;
      budget++;
      if (en_i) begin
        strobes++;
        if (strobes % 16 == 0 && strobes >= 32) v_due = cyc + 2;
      end
      exp_v = (cyc == v_due);
      check({tag, "/valid"}, 32'(valid_o), 32'(exp_v));
      if (valid_o) begin
        n_valid++;
        check({tag, "/data"}, 32'(data_o), 32'(exp_data));
        check({tag, "/sat"}, 32'(sat_o), 32'(exp_sat));
      end
    end
    if (budget >= 2000) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s/budget: got %0d cycles expected fewer than 2000", tag, budget);
    end
    check({tag, "/count"}, 32'(n_valid), 32'(exp_valids));
  endtask

  initial begin
    do_reset();
    check("reset/data", 32'(data_o), 32'h0);
    check("reset/valid", 32'(valid_o), 32'h0);
    check("reset/sat", 32'(sat_o), 32'h0);

    run("ones", 4'b1111, 64, 1'b0, 8'h7f, 1'b1, 3, 3);
    do_reset();
    run("zeros", 4'b0000, 64, 1'b0, 8'h80, 1'b0, 3, 3);
    do_reset();
    run("alt", 4'b0101, 64, 1'b0, 8'h00, 1'b0, 3, 3);
    do_reset();
    run("d75", 4'b0111, 64, 1'b0, 8'h40, 1'b0, 3, 3);
    do_reset();
    run("d75gap", 4'b0111, 64, 1'b1, 8'h40, 1'b0, 3, 3);

    // Reset one cycle after E0, with data_o already holding 127 from earlier results.
    do_reset();
    run("rst_pre", 4'b1111, 64, 1'b0, 8'h7f, 1'b1, 2, 1);
    rst_i = 1'b0;
    #1;
    check("rst_async/data", 32'(data_o), 32'h0);
    check("rst_async/valid", 32'(valid_o), 32'h0);
    check("rst_async/sat", 32'(sat_o), 32'h0);
    en_i  = 1'b1;
    bit_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_hold/valid", 32'(valid_o), 32'h0);
    check("rst_hold/data", 32'(data_o), 32'h0);
    en_i    = 1'b0;
    rst_i   = 1'b1;
    cyc     = 0;
    strobes = 0;
    v_due   = -1;
    run("rst_post", 4'b1111, 48, 1'b0, 8'h7f, 1'b1, 2, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
